// File: rtl/au_muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   AU_*   : ArithmeticUnit S select encodings
//   OP_*   : operation select on the request bus
//   state_t: sequencer FSM states
package au_muldiv_seq_pkg;

  localparam logic [1:0] AU_XFER = 2'b00;  // A + Cin
  localparam logic [1:0] AU_ADD  = 2'b01;  // A + B + Cin
  localparam logic [1:0] AU_SUB  = 2'b10;  // A + ~B + Cin
  localparam logic [1:0] AU_DEC  = 2'b11;  // A - 1 + Cin

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/au_muldiv_seq_if.sv
// Request/result bus between the control unit and the multiply/divide
// sequencer.
//   start, op, opA, opB      : request from the control unit
//   busy, done              : sequencer status
//   res_lo, res_hi, dbz     : results, valid with done and held afterwards
// master = control unit side, slave = sequencer side.
interface au_muldiv_seq_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             dbz;

  modport master (
    output start, op, opA, opB,
    input  busy, done, res_lo, res_hi, dbz
  );

  modport slave (
    input  start, op, opA, opB,
    output busy, done, res_lo, res_hi, dbz
  );

endinterface

// File: rtl/au_muldiv_seq.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) sequencer
// that borrows the external ArithmeticUnit for one add/subtract per cycle.
//   clk, rst_n      : clock, synchronous active-low reset
//   bus (slave)     : start/op/opA/opB request, busy/done/res_lo/res_hi/dbz
//   au_A/B/S/Cin    : drive to the shared AU (all zero outside RUN)
//   au_out, au_Cout : AU result and carry out
//
// state | meaning
// IDLE  | waiting; one extra IDLE cycle after accept resolves divide-by-zero
// RUN   | one shift-add / restoring-subtract iteration per cycle
// DONE  | one-cycle done pulse, results valid
module au_muldiv_seq
  import au_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  au_muldiv_seq_if.slave   bus,
  output logic [WIDTH-1:0] au_A,
  output logic [WIDTH-1:0] au_B,
  output logic [1:0]       au_S,
  output logic             au_Cin,
  input  logic [WIDTH-1:0] au_out,
  input  logic             au_Cout
);

  state_t           state_q, state_d;
  logic             pend_q;   // request latched, not yet dispatched
  logic             op_q;
  logic [WIDTH-1:0] hi_q;     // P_hi (multiply) / R (divide)
  logic [WIDTH-1:0] lo_q;     // P_lo (multiply) / Q (divide)
  logic [WIDTH-1:0] m_q;      // multiplicand / divisor
  logic [CNT_W-1:0] cnt_q;
  logic             dbz_q;

  logic             accept;
  logic             go_run;
  logic             go_dbz;
  logic [WIDTH-1:0] rs;
  logic             qbit;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    go_run  = 1'b0;
    go_dbz  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          if (op_q == OP_DIV && m_q == '0) begin
            state_d = DONE;
            go_dbz  = 1'b1;
          end else begin
            state_d = RUN;
            go_run  = 1'b1;
          end
        end else if (bus.start) begin
          accept = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shifted partial remainder; R[31] is the 33rd bit of the compare, so a
  // set rmsb means Rs >= D regardless of the AU carry.
  assign rs   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign qbit = hi_q[WIDTH-1] | au_Cout;

  always_comb begin
    au_A   = '0;
    au_B   = '0;
    au_S   = AU_XFER;
    au_Cin = 1'b0;
    if (state_q == RUN) begin
      au_B = m_q;
      if (op_q == OP_MUL) begin
        au_A   = hi_q;
        au_S   = AU_ADD;
        au_Cin = 1'b0;
      end else begin
        au_A   = rs;
        au_S   = AU_SUB;
        au_Cin = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      op_q    <= OP_MUL;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pend_q <= 1'b1;
        op_q   <= bus.op;
        dbz_q  <= 1'b0;
        hi_q   <= '0;
        lo_q   <= (bus.op == OP_DIV) ? bus.opA : bus.opB;
        m_q    <= (bus.op == OP_DIV) ? bus.opB : bus.opA;
      end
      if (go_run) begin
        pend_q <= 1'b0;
        cnt_q  <= CNT_W'(WIDTH - 1);
      end
      if (go_dbz) begin
        pend_q <= 1'b0;
        hi_q   <= lo_q;
        lo_q   <= '1;
        dbz_q  <= 1'b1;
      end
      if (state_q == RUN) begin
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        if (op_q == OP_MUL) begin
          if (lo_q[0]) {hi_q, lo_q} <= {au_Cout, au_out, lo_q[WIDTH-1:1]};
          else         {hi_q, lo_q} <= {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end else begin
          hi_q <= qbit ? au_out : rs;
          lo_q <= {lo_q[WIDTH-2:0], qbit};
        end
      end
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.res_lo = lo_q;
  assign bus.res_hi = hi_q;
  assign bus.dbz    = dbz_q;

endmodule

// File: tb/tb_au_muldiv_seq.sv
// Directed bench for au_muldiv_seq with a behavioural ArithmeticUnit.
module tb_au_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] au_A, au_B, au_out;
  logic [1:0]  au_S;
  logic        au_Cin, au_Cout;
  logic [32:0] au_sum;

  int n_chk = 0;
  int n_err = 0;

  au_muldiv_seq_if #(.WIDTH(32)) bus ();

  au_muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .au_A   (au_A),
    .au_B   (au_B),
    .au_S   (au_S),
    .au_Cin (au_Cin),
    .au_out (au_out),
    .au_Cout(au_Cout)
  );

  // ArithmeticUnit reference behaviour
  always_comb begin
    au_sum = '0;
    case (au_S)
      2'b00:   au_sum = {1'b0, au_A} + {32'b0, au_Cin};
      2'b01:   au_sum = {1'b0, au_A} + {1'b0, au_B} + {32'b0, au_Cin};
      2'b10:   au_sum = {1'b0, au_A} + {1'b0, ~au_B} + {32'b0, au_Cin};
      default: au_sum = {1'b0, au_A} + {1'b0, 32'hFFFF_FFFF} + {32'b0, au_Cin};
    endcase
  end
  assign au_out  = au_sum[31:0];
  assign au_Cout = au_sum[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Issues one request (start sampled at the next edge k) and follows it.
  // exp_edge: index n of the edge k+n after which done is first high.
  // inj > 0 : a start with other operands is presented after edge k+inj.
  task automatic run_op(input string tag, input logic o, input logic [31:0] a,
                        input logic [31:0] b, input int inj,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input logic exp_dbz, input int exp_edge, input int exp_busy);
    int          n = 0;
    int          busy_n = 0;
    bit          seen = 0;
    bit          overlap = 0;
    logic [1:0]  s_mid = 2'b00;
    logic        cin_mid = 1'b0;
    bus.op    = o;
    bus.opA   = a;
    bus.opB   = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (!seen && n < 200) begin
      if (bus.busy && bus.done) overlap = 1;
      if (n == 5) begin
        s_mid   = au_S;
        cin_mid = au_Cin;
      end
      if (bus.done) begin
        seen = 1;
      end else begin
        if (bus.busy) busy_n++;
        if (inj > 0 && n == inj) begin
          bus.start = 1'b1;
          bus.op    = 1'b0;
          bus.opA   = 32'd3;
          bus.opB   = 32'd3;
        end else begin
          bus.start = 1'b0;
        end
        @(posedge clk); #1;
        n++;
      end
    end
    bus.start = 1'b0;
    chk({tag, "_seen"}, seen, 1);
    chk({tag, "_edge"}, n, exp_edge);
    chk({tag, "_busy"}, busy_n, exp_busy);
    chk({tag, "_lo"}, bus.res_lo, exp_lo);
    chk({tag, "_hi"}, bus.res_hi, exp_hi);
    chk({tag, "_dbz"}, bus.dbz, exp_dbz);
    chk({tag, "_ovl"}, overlap, 0);
    chk({tag, "_au_done"}, {au_A, au_B}, 64'h0);
    if (!exp_dbz) begin
      chk({tag, "_au_s"}, s_mid, o ? 2'b10 : 2'b01);
      chk({tag, "_au_cin"}, cin_mid, o ? 1'b1 : 1'b0);
    end
    @(posedge clk); #1;
    chk({tag, "_pulse"}, bus.done, 0);
    chk({tag, "_hold_lo"}, bus.res_lo, exp_lo);
  endtask

  initial begin
    int dn;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.opA   = '0;
    bus.opB   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz", bus.dbz, 0);
    chk("rst_res", {bus.res_hi, bus.res_lo}, 64'h0);
    chk("rst_au", {au_A, au_B}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul7x6", 1'b0, 32'd7, 32'd6, 0, 32'h2A, 32'h0, 1'b0, 33, 32);
    run_op("mulff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,
           32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33, 32);
    run_op("mul64k", 1'b0, 32'h0001_0000, 32'h0001_0000, 0,
           32'h0000_0000, 32'h0000_0001, 1'b0, 33, 32);
    run_op("div100_7", 1'b1, 32'd100, 32'd7, 0, 32'd14, 32'd2, 1'b0, 33, 32);
    run_op("div_rmsb", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0,
           32'h1, 32'h7FFF_FFFE, 1'b0, 33, 32);
    run_op("div7_100", 1'b1, 32'd7, 32'd100, 0, 32'd0, 32'd7, 1'b0, 33, 32);
    run_op("div_zero", 1'b1, 32'h1234, 32'h0, 0,
           32'hFFFF_FFFF, 32'h1234, 1'b1, 1, 0);
    run_op("mul_ign", 1'b0, 32'd5, 32'd5, 10, 32'd25, 32'd0, 1'b0, 33, 32);

    // Reset in the middle of an operation
    bus.op    = 1'b0;
    bus.opA   = 32'h1234;
    bus.opB   = 32'h5678;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_res", {bus.res_hi, bus.res_lo}, 64'h0);
    chk("abort_dbz", bus.dbz, 0);
    chk("abort_au", {au_A, au_B}, 64'h0);
    chk("abort_au_s", {au_S, au_Cin}, 3'b000);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dn++;
    end
    chk("abort_quiet", dn, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
